// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised multi-cycle CPU: opcodes, FSM states, status bits.
// No logic of its own; latency and backpressure belong to the modules that import it.
// Opcode values and status bit positions are part of the software-visible contract.
package cpu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_STORE  = 8'h02;
  localparam logic [7:0] OP_LOADLI = 8'h03;
  localparam logic [7:0] OP_LOADHI = 8'h04;
  localparam logic [7:0] OP_JUMPZ  = 8'h05;
  localparam logic [7:0] OP_MOV    = 8'h06;
  localparam logic [7:0] OP_AND    = 8'h07;
  localparam logic [7:0] OP_OR     = 8'h08;
  localparam logic [7:0] OP_XOR    = 8'h09;
  localparam logic [7:0] OP_ADD    = 8'h0A;
  localparam logic [7:0] OP_SUB    = 8'h0B;
  localparam logic [7:0] OP_JUMPNZ = 8'h0C;
  localparam logic [7:0] OP_LOADR  = 8'h0D;
  localparam logic [7:0] OP_STORER = 8'h0E;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  // Bit positions inside the 8-bit status output.
  localparam int ST_Z    = 0;
  localparam int ST_C    = 1;
  localparam int ST_BOOT = 5;
  localparam int ST_ILL  = 6;
  localparam int ST_HALT = 7;

  typedef enum logic [2:0] {
    IFETCH,
    ICAP,
    EXEC,
    MWAIT,
    MCAP,
    HLT
  } state_t;

  // Opcodes whose result goes through the ALU and updates the Z flag.
  function automatic logic is_alu_op(input logic [7:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
           (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for AND/OR/XOR/ADD/SUB with zero and carry/borrow flags.
// Latency: zero cycles, purely combinational.
// No handshake: the caller decides which results and flags it commits.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] sum;

  // Compute result and flags; SUB borrow appears as the extra top bit of the wide difference.
  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      default: result = '0;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/cpu_param.sv
// Multi-cycle CPU: fetch/capture/execute over one synchronous RAM port, NREG x DATA_W register file.
// Latency: 3 cycles per ALU/immediate/branch/NOP, 4 per store, 5 per load.
// No backpressure: the RAM must return read data one cycle after the address is stable.
module cpu_param
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int NREG     = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic [7:0]        status
);

  localparam int RW = $clog2(NREG);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              z_q, z_d, c_q, c_d;
  logic              boot_q, boot_d, ill_q, ill_d, halt_q, halt_d;
  logic [DATA_W-1:0] regs_q [NREG];

  logic              rf_we;
  logic [RW-1:0]     rf_wa;
  logic [DATA_W-1:0] rf_wd;

  logic [7:0]        op;
  logic [15:0]       imm;
  logic [RW-1:0]     ra_idx, rb_idx, rc_idx;
  logic [DATA_W-1:0] ra_val, rb_val, alu_res;
  logic              alu_z, alu_c;
  logic [ADDR_W-1:0] pc_seq, pc_br, imm_addr, reg_addr;
  logic              is_load;

  // Field decode; register indices wrap modulo NREG by truncation.
  assign op       = cmd_q[31:24];
  assign imm      = cmd_q[15:0];
  assign ra_idx   = RW'(cmd_q[23:16]);
  assign rb_idx   = RW'(cmd_q[15:8]);
  assign rc_idx   = RW'(cmd_q[7:0]);
  assign ra_val   = regs_q[ra_idx];
  assign rb_val   = regs_q[rb_idx];
  assign pc_seq   = pc_q + ADDR_W'(1);
  assign pc_br    = pc_q + ADDR_W'({{16{imm[15]}}, imm});
  assign imm_addr = ADDR_W'(imm);
  assign reg_addr = ADDR_W'(rb_val);
  assign is_load  = (op == OP_LOAD) || (op == OP_LOADR);

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (ra_val),
    .b      (rb_val),
    .op     (op),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  // Next-state, register-file write and RAM-side outputs; everything holds unless a state changes it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    wren_d  = wren_q;
    z_d     = z_q;
    c_d     = c_q;
    boot_d  = boot_q;
    ill_d   = ill_q;
    halt_d  = halt_q;
    rf_we   = 1'b0;
    rf_wa   = ra_idx;
    rf_wd   = ra_val;
    case (state_q)
      IFETCH: state_d = ICAP;
      ICAP: begin
        cmd_d   = q[31:0];
        boot_d  = 1'b0;
        state_d = EXEC;
      end
      EXEC: begin
        pc_d    = pc_seq;
        addr_d  = pc_seq;
        state_d = IFETCH;
        if (is_alu_op(op)) begin
          rf_we = 1'b1;
          rf_wa = rc_idx;
          rf_wd = alu_res;
          z_d   = alu_z;
          if ((op == OP_ADD) || (op == OP_SUB)) c_d = alu_c;
        end else begin
          case (op)
            OP_NOP: ;
            OP_LOAD: begin
              addr_d  = imm_addr;
              state_d = MWAIT;
            end
            OP_LOADR: begin
              addr_d  = reg_addr;
              state_d = MWAIT;
            end
            OP_STORE, OP_STORER: begin
              addr_d  = (op == OP_STORE) ? imm_addr : reg_addr;
              data_d  = ra_val;
              wren_d  = 1'b1;
              state_d = MWAIT;
            end
            OP_LOADLI: begin
              rf_we        = 1'b1;
              rf_wd[15:0]  = imm;
            end
            OP_LOADHI: begin
              rf_we        = 1'b1;
              rf_wd[31:16] = imm;
            end
            OP_MOV: begin
              rf_we = 1'b1;
              rf_wa = rb_idx;
            end
            OP_JUMPZ, OP_JUMPNZ: begin
              if ((ra_val == '0) == (op == OP_JUMPZ)) begin
                pc_d   = pc_br;
                addr_d = pc_br;
              end
            end
            OP_HALT: begin
              halt_d  = 1'b1;
              addr_d  = addr_q;
              state_d = HLT;
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      MWAIT: begin
        wren_d = 1'b0;
        if (is_load) begin
          state_d = MCAP;
        end else begin
          addr_d  = pc_q;
          state_d = IFETCH;
        end
      end
      MCAP: begin
        rf_we   = 1'b1;
        rf_wd   = q;
        addr_d  = pc_q;
        state_d = IFETCH;
      end
      HLT: wren_d = 1'b0;
      default: state_d = IFETCH;
    endcase
  end

  // Control, pc, RAM-side and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IFETCH;
      pc_q    <= RST_PC;
      addr_q  <= RST_PC;
      cmd_q   <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      boot_q  <= 1'b1;
      ill_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      z_q     <= z_d;
      c_q     <= c_d;
      boot_q  <= boot_d;
      ill_q   <= ill_d;
      halt_q  <= halt_d;
    end
  end

  // Register file: cleared on reset, one write port driven from EXEC or MCAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_wa] <= rf_wd;
    end
  end

  // Pack the flag registers into the status byte; unused bits read as zero.
  always_comb begin
    status          = '0;
    status[ST_Z]    = z_q;
    status[ST_C]    = c_q;
    status[ST_BOOT] = boot_q;
    status[ST_ILL]  = ill_q;
    status[ST_HALT] = halt_q;
  end

  assign data    = data_q;
  assign address = addr_q;
  assign wren    = wren_q;

endmodule

// File: tb/tb_cpu_param.sv
module tb_cpu_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 32-bit data, 16-bit address, 8 registers, start at 0.
  logic        rst1;
  logic [31:0] q1, data1;
  logic [15:0] addr1;
  logic        wren1;
  logic [7:0]  st1;

  // Wide instance: 64-bit data, 12-bit address, 4 registers, start at the last address.
  logic        rst2;
  logic [63:0] q2, data2;
  logic [11:0] addr2;
  logic        wren2;
  logic [7:0]  st2;

  cpu_param dut1 (
    .clk(clk), .reset(rst1), .q(q1), .data(data1),
    .address(addr1), .wren(wren1), .status(st1)
  );

  cpu_param #(.DATA_W(64), .ADDR_W(12), .NREG(4), .RESET_PC('hFFF)) dut2 (
    .clk(clk), .reset(rst2), .q(q2), .data(data2),
    .address(addr2), .wren(wren2), .status(st2)
  );

  // RAM models with a bench-side load port used only while the cores are in reset.
  logic        ld_en;
  int          ld_sel;
  logic [15:0] ld_a;
  logic [31:0] ld_d;
  logic [31:0] mem1 [65536];
  logic [63:0] mem2 [4096];

  always @(posedge clk) begin
    if (ld_en && ld_sel == 1) mem1[ld_a] <= ld_d;
    else if (wren1) mem1[addr1] <= data1;
    if (ld_en && ld_sel == 2) mem2[ld_a[11:0]] <= {32'h0, ld_d};
    else if (wren2) mem2[addr2] <= data2;
    q1 <= mem1[addr1];
    q2 <= mem2[addr2];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard entry: one expected RAM write with the status visible while it happens.
  typedef struct packed {
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];

  task automatic push(input int sel, input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    exp_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    if (sel == 1) sb1.push_back(e);
    else sb2.push_back(e);
  endtask

  task automatic ld(input int sel, input logic [15:0] a, input logic [31:0] d);
    ld_sel = sel;
    ld_a   = a;
    ld_d   = d;
    ld_en  = 1'b1;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  // Monitors: every wren pulse pops one expectation; a pulse must never last two cycles.
  logic pw1 = 1'b0;
  logic pw2 = 1'b0;
  exp_t m1, m2;

  always @(negedge clk) begin
    if (wren1) begin
      chk("dut1_wren_one_cycle", 64'(pw1), 64'h0);
      if (sb1.size() == 0) begin
        chk("dut1_unexpected_store", 64'(addr1), 64'hFFFF_FFFF);
      end else begin
        m1 = sb1.pop_front();
        chk("dut1_store_addr", 64'(addr1), 64'(m1.a));
        chk("dut1_store_data", 64'(data1), m1.d);
        chk("dut1_store_status", 64'(st1), 64'(m1.s));
      end
    end
    pw1 = wren1;
  end

  always @(negedge clk) begin
    if (wren2) begin
      chk("dut2_wren_one_cycle", 64'(pw2), 64'h0);
      if (sb2.size() == 0) begin
        chk("dut2_unexpected_store", 64'(addr2), 64'hFFFF_FFFF);
      end else begin
        m2 = sb2.pop_front();
        chk("dut2_store_addr", 64'(addr2), 64'(m2.a));
        chk("dut2_store_data", data2, m2.d);
        chk("dut2_store_status", 64'(st2), 64'(m2.s));
      end
    end
    pw2 = wren2;
  end

  // Program for dut1 at address 0.
  logic [31:0] p1 [27] = '{
    32'h00000000,  // 00 NOP
    32'h03010005,  // 01 LOADLI r1,5
    32'h03020007,  // 02 LOADLI r2,7
    32'h0B010203,  // 03 SUB r3=r1-r2 -> FFFFFFFE, C=1
    32'h02030040,  // 04 STORE r3 -> 0x40
    32'h03010002,  // 05 LOADLI r1,2
    32'h0A030104,  // 06 ADD r4=r3+r1 -> 0, Z=1 C=1
    32'h02040042,  // 07 STORE r4 -> 0x42
    32'h01050040,  // 08 LOAD r5 <- 0x40
    32'h03060041,  // 09 LOADLI r6,0x41
    32'h06060000,  // 0A MOV r0 <- r6
    32'h0E050600,  // 0B STORER r5 -> [r6]
    32'h0D070600,  // 0C LOADR r7 <- [r6]
    32'h04071234,  // 0D LOADHI r7,0x1234
    32'h02070044,  // 0E STORE r7 -> 0x44 (visited twice)
    32'h09000600,  // 0F XOR r0=r0^r6
    32'h0500FFFE,  // 10 JUMPZ r0,-2
    32'h02000045,  // 11 STORE r0 -> 0x45
    32'h09000000,  // 12 XOR r0=r0^r0 -> 0
    32'h0C000003,  // 13 JUMPNZ r0,+3 (not taken)
    32'h0B020103,  // 14 SUB r3=r2-r1 -> 5
    32'h02030046,  // 15 STORE r3 -> 0x46
    32'h77030303,  // 16 illegal opcode
    32'h02030047,  // 17 STORE r3 -> 0x47
    32'h07010203,  // 18 AND r3=r1&r2 -> 2
    32'h02030048,  // 19 STORE r3 -> 0x48
    32'hFF000000   // 1A HALT
  };

  // Program for dut2 at 0x000; 0xFFF holds the NOP that wraps into it.
  logic [31:0] p2 [8] = '{
    32'h0306BEEF,  // 000 LOADLI r6 (= r2),0xBEEF
    32'h04021234,  // 001 LOADHI r2,0x1234
    32'h02020010,  // 002 STORE r2 -> 0x010
    32'h0B000201,  // 003 SUB r1=r0-r2
    32'h02010011,  // 004 STORE r1 -> 0x011
    32'h0A010207,  // 005 ADD r7 (= r3)=r1+r2 -> 0
    32'h02070012,  // 006 STORE r3 -> 0x012
    32'hFF000000   // 007 HALT
  };

  initial begin
    rst1  = 1'b1;
    rst2  = 1'b1;
    ld_en = 1'b0;
    ld_sel = 0;
    ld_a  = '0;
    ld_d  = '0;

    for (int i = 0; i < 27; i++) ld(1, 16'(i), p1[i]);
    for (int i = 0; i < 8; i++) ld(2, 16'(i), p2[i]);
    ld(2, 16'hFFF, 32'h0);

    // Reset state.
    chk("rst_addr1", 64'(addr1), 64'h0);
    chk("rst_wren1", 64'(wren1), 64'h0);
    chk("rst_status1", 64'(st1), 64'h20);
    chk("rst_addr2", 64'(addr2), 64'hFFF);
    chk("rst_status2", 64'(st2), 64'h20);

    push(1, 16'h40, 64'hFFFF_FFFE, 8'h02);
    push(1, 16'h42, 64'h0,         8'h03);
    push(1, 16'h41, 64'hFFFF_FFFE, 8'h03);
    push(1, 16'h44, 64'h1234_FFFE, 8'h03);
    push(1, 16'h44, 64'h1234_FFFE, 8'h03);
    push(1, 16'h45, 64'h41,        8'h02);
    push(1, 16'h46, 64'h5,         8'h00);
    push(1, 16'h47, 64'h5,         8'h40);
    push(1, 16'h48, 64'h2,         8'h40);
    push(2, 16'h010, 64'h0000_0000_1234_BEEF, 8'h02 & 8'h00);
    push(2, 16'h011, 64'hFFFF_FFFF_EDCB_4111, 8'h02);
    push(2, 16'h012, 64'h0,                   8'h03);

    rst1 = 1'b0;
    rst2 = 1'b0;

    // First NOP: boot bit gone, next fetch address (dut2 wraps 0xFFF -> 0x000).
    repeat (3) @(negedge clk);
    chk("nop_addr1", 64'(addr1), 64'h1);
    chk("nop_status1", 64'(st1), 64'h00);
    chk("nop_wrap_addr2", 64'(addr2), 64'h000);
    chk("nop_status2", 64'(st2), 64'h00);

    for (int i = 0; i < 3000 && !(st1[7] && st2[7]); i++) @(negedge clk);
    chk("halt_status1", 64'(st1), 64'hC0);
    chk("halt_status2", 64'(st2), 64'h83);
    chk("halt_addr2", 64'(addr2), 64'h007);
    for (int i = 0; i < 20; i++) begin
      chk("halt_addr1_frozen", 64'(addr1), 64'h1A);
      chk("halt_wren1_low", 64'(wren1), 64'h0);
      @(negedge clk);
    end
    chk("sb1_drained", 64'(sb1.size()), 64'h0);
    chk("sb2_drained", 64'(sb2.size()), 64'h0);

    // Reset out of HLT restarts at address 0.
    rst1 = 1'b1;
    @(negedge clk);
    chk("hlt_rst_addr1", 64'(addr1), 64'h0);
    chk("hlt_rst_status1", 64'(st1), 64'h20);

    // Rerun to the first store and reset during its wren cycle.
    push(1, 16'h40, 64'hFFFF_FFFE, 8'h02);
    rst1 = 1'b0;
    for (int i = 0; i < 200 && !wren1; i++) @(negedge clk);
    chk("midstore_reached", 64'(wren1), 64'h1);
    rst1 = 1'b1;
    @(negedge clk);
    chk("midstore_wren1", 64'(wren1), 64'h0);
    chk("midstore_addr1", 64'(addr1), 64'h0);
    chk("midstore_status1", 64'(st1), 64'h20);
    rst1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midstore_restart_addr1", 64'(addr1), 64'h1);
    rst1 = 1'b1;
    @(negedge clk);
    chk("sb1_drained_end", 64'(sb1.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
